im_fetch_ctrl: RTL and testbench

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

---
 rtl/im_fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_fifo2.sv | 66 ++++++
 rtl/im_fetch_ctrl.sv | 82 ++++++++
 tb/tb_im_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_ctrl_pkg.sv
// rtl/im_fetch_ctrl_pkg.sv - shared fetch-control state encoding, entry type and pc helpers
package im_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Redirect targets are forced to a word boundary and folded into the memory window.
    function automatic logic [31:0] pc_align_wrap(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return {addr[31:2], 2'b00} % mem_bytes;
    endfunction

    function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return ((pc + 32'd4) >= mem_bytes) ? 32'd0 : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - two-entry {instr, pc} fetch buffer with flush and head outputs
module fetch_fifo2
    import im_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] din_instr,
    input  logic [31:0] din_pc,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    fetch_entry_t din;
    logic [1:0]   cnt;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        din     = '{instr: din_instr, pc: din_pc};
        pop_ok  = pop && (cnt != 2'd0);
        push_ok = push && ((cnt != 2'd2) || pop_ok);
    end

    // e0 is always the head; a pop shifts e1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = cnt;
    assign head_instr = e0.instr;
    assign head_pc    = e0.pc;

endmodule

// File: rtl/im_fetch_ctrl.sv
// rtl/im_fetch_ctrl.sv - instruction fetch controller: pc sequencing, redirect, halt and 2-deep buffer
module im_fetch_ctrl
    import im_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 32,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] im_adress,
    input  logic [31:0] im_instruction,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    logic         flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == ST_HALT);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (push && (im_instruction == HALT_WORD)) state_next = ST_HALT;
            ST_HALT: if (redir_valid) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // Redirect outranks everything: no push/pop the cycle it is seen, so a halt word can't latch HALT.
    always_comb begin
        flush = redir_valid && (state != ST_IDLE);
        pop   = if_valid && if_ready && !redir_valid;
        push  = (state == ST_RUN) && !redir_valid && ((count != 2'd2) || pop);
        if (redir_valid) pc_next = pc_align_wrap(redir_pc, MEM_LIMIT);
        else if (push)   pc_next = pc_step(pc, MEM_LIMIT);
        else             pc_next = pc;
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .din_instr  (im_instruction),
        .din_pc     (pc),
        .count      (count),
        .head_instr (if_instr),
        .head_pc    (if_pc)
    );

    assign im_adress = pc;
    assign if_valid  = (count != 2'd0);

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb/tb_im_fetch_ctrl.sv - directed plus randomized bench for im_fetch_ctrl against a queue model
module tb_im_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_BYTES = 32;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] im_adress;
    logic [31:0] im_instruction;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    logic [31:0] mem [0:MEM_BYTES/4-1];
    int          passed = 0;
    int          total = 0;

    ent_t        q[$];
    int          m_st;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    assign im_instruction = mem[im_adress[4:2]];

    im_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES), .HALT_WORD(HALT_WORD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .im_adress      (im_adress),
        .im_instruction (im_instruction),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("m_adr", im_adress, m_pc);
        chk("m_valid", 32'(if_valid), 32'(q.size() != 0));
        chk("m_halted", 32'(halted), 32'(m_st == 2));
        if (q.size() != 0) begin
            chk("m_instr", if_instr, q[0].instr);
            chk("m_pc", if_pc, q[0].pc);
        end
    endtask

    // 0 = idle, 1 = run, 2 = halt; behaviour written directly from the fetch rules.
    task automatic model_step(input logic s, input logic rv, input logic [31:0] rp, input logic rdy);
        logic [31:0] tgt;
        logic [31:0] w;
        bit          pop_now;
        bit          push_now;
        tgt = (rp & 32'hFFFF_FFFC) % MEM_BYTES;
        if (m_st == 0) begin
            if (rv) m_pc = tgt;
            if (s) m_st = 1;
        end else if (rv) begin
            q.delete();
            m_pc = tgt;
            m_st = 1;
        end else begin
            pop_now  = (q.size() != 0) && rdy;
            push_now = (m_st == 1) && ((q.size() < 2) || pop_now);
            w = mem[m_pc / 4];
            if (pop_now) void'(q.pop_front());
            if (push_now) begin
                q.push_back('{instr: w, pc: m_pc});
                m_pc = (m_pc + 4 >= MEM_BYTES) ? 32'd0 : m_pc + 4;
                if (w == HALT_WORD) m_st = 2;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = 0;
        m_pc = RESET_PC;
    endtask

    task automatic cycle(input logic s, input logic rv, input logic [31:0] rp, input logic rdy);
        start = s;
        redir_valid = rv;
        redir_pc = rp;
        if_ready = rdy;
        check_model();
        @(posedge clk);
        model_step(s, rv, rp, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 1'b0;
        redir_valid = 1'b0;
        if_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] = 32'h1111_1111 * 32'(i + 1);
        model_reset();
        do_reset();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_adr", im_adress, RESET_PC);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Streaming with decode always ready.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("no_push_on_start", 32'(if_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq_pc0", if_pc, 32'd0);
        chk("seq_instr0", if_instr, 32'h1111_1111);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq_pc4", if_pc, 32'd4);
        chk("seq_instr4", if_instr, 32'h2222_2222);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq_pc8", if_pc, 32'd8);

        // Backpressure stall then release.
        do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_adr", im_adress, 32'd8);
        chk("stall_head", if_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("release_pc", if_pc, 32'(i * 4));
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Redirect with a full buffer.
        cycle(1'b0, 1'b1, 32'h0000_0013, 1'b0);
        chk("redir_flush", 32'(if_valid), 32'd0);
        chk("redir_adr", im_adress, 32'h10);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("redir_head", if_pc, 32'h10);

        // Wrap at the end of memory.
        cycle(1'b0, 1'b1, 32'd24, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_24", if_pc, 32'd24);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_28", if_pc, 32'd28);
        chk("wrap_adr", im_adress, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_0", if_pc, 32'd0);

        // Halt word at pc 8, then resume by redirect.
        mem[2] = HALT_WORD;
        cycle(1'b0, 1'b1, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("halt_head", if_pc, 32'd8);
        chk("halt_instr", if_instr, HALT_WORD);
        chk("halt_flag", 32'(halted), 32'd1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("halt_nopush", 32'(if_valid), 32'd0);
        chk("halt_adr", im_adress, 32'd12);
        cycle(1'b0, 1'b1, 32'd0, 1'b1);
        chk("resume_run", 32'(halted), 32'd0);
        mem[2] = 32'h3333_3333;
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("resume_pc", if_pc, 32'd0);

        // Asynchronous reset with a full buffer.
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("pre_rst_full", 32'(if_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_adr", im_adress, RESET_PC);
        chk("arst_halted", 32'(halted), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("idle_after_rst", 32'(if_valid), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < MEM_BYTES / 4; i++)
            mem[i] = ($urandom_range(5) == 0) ? HALT_WORD : $urandom;
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(15) == 0), 1'($urandom_range(19) == 0), $urandom, 1'($urandom_range(1)));
        end
        check_model();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
